// File: rtl/fpu_exception_stage.sv
// Final stage of the single-precision add/sub FPU: side-band delay line, IEEE special-value
// handling, result register and sticky flags. Define FPU_EXC_COUNT_EN to add the ExcCount port.
module fpu_exception_stage #(
    parameter int LATENCY      = 6,
    parameter int DataSize     = 32,
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IssueValid,
    input  logic [DataSize-1:0]     IssueOperand1,
    input  logic [DataSize-1:0]     IssueOperand2,
    input  logic                    IssueOperation,
    input  logic [ExponentSize-1:0] DpExponent,
    input  logic [FractionSize-1:0] DpFraction,
    input  logic                    DpExpCarry,
    input  logic                    FlagClr,
    output logic [DataSize-1:0]     Result,
    output logic                    ResultValid,
    output logic [2:0]              Flags
`ifdef FPU_EXC_COUNT_EN
    ,
    output logic [15:0]             ExcCount
`endif
);

    localparam int MagSize = DataSize - 1;
    localparam logic [DataSize-1:0] QuietNan =
        {1'b0, {ExponentSize{1'b1}}, 1'b1, {(FractionSize-1){1'b0}}};

    typedef struct packed {
        logic               valid;
        logic               s1;
        logic               s2;
        logic               nan1;
        logic               inf1;
        logic               zero1;
        logic               nan2;
        logic               inf2;
        logic               zero2;
        logic               s_large;
        logic               eq_cancel;
        logic [MagSize-1:0] mag1;
        logic [MagSize-1:0] mag2;
    } side_t;

    logic [ExponentSize-1:0] e1, e2;
    logic [FractionSize-1:0] f1, f2;
    logic                    fin1, fin2;
    side_t                   issue_entry;
    side_t                   dl [1:LATENCY];
    side_t                   tail;
    logic [DataSize-1:0]     sel_result;
    logic [2:0]              ev;
    logic                    inf_sign;

    assign e1 = IssueOperand1[DataSize-2 -: ExponentSize];
    assign e2 = IssueOperand2[DataSize-2 -: ExponentSize];
    assign f1 = IssueOperand1[FractionSize-1:0];
    assign f2 = IssueOperand2[FractionSize-1:0];

    always_comb begin
        issue_entry       = '0;
        issue_entry.valid = IssueValid;
        issue_entry.s1    = IssueOperand1[DataSize-1];
        issue_entry.s2    = IssueOperand2[DataSize-1] ^ IssueOperation;
        issue_entry.nan1  = (e1 == '1) && (f1 != '0);
        issue_entry.inf1  = (e1 == '1) && (f1 == '0);
        issue_entry.zero1 = (e1 == '0);
        issue_entry.nan2  = (e2 == '1) && (f2 != '0);
        issue_entry.inf2  = (e2 == '1) && (f2 == '0);
        issue_entry.zero2 = (e2 == '0);
        issue_entry.mag1  = IssueOperand1[MagSize-1:0];
        issue_entry.mag2  = IssueOperand2[MagSize-1:0];
        // Ties pick operand 1; a tie with opposite signs is caught by eq_cancel anyway.
        issue_entry.s_large = (issue_entry.mag1 >= issue_entry.mag2) ? issue_entry.s1
                                                                      : issue_entry.s2;
        issue_entry.eq_cancel = (issue_entry.mag1 == issue_entry.mag2) && fin1 && fin2 &&
                                (issue_entry.s1 != issue_entry.s2);
    end

    assign fin1 = (e1 != '1) && (e1 != '0);
    assign fin2 = (e2 != '1) && (e2 != '0);

    // The tail entry was issued LATENCY edges ago, lining up with the Dp* inputs.
    assign tail     = dl[LATENCY];
    assign inf_sign = tail.inf1 ? tail.s1 : tail.s2;

    always_comb begin
        sel_result = '0;
        ev         = '0;
        if (tail.nan1 || tail.nan2 || (tail.inf1 && tail.inf2 && (tail.s1 != tail.s2))) begin
            sel_result = QuietNan;
            ev[2]      = 1'b1;
        end else if (tail.inf1 || tail.inf2) begin
            sel_result = {inf_sign, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
        end else if (tail.zero1 && tail.zero2) begin
            sel_result = {tail.s1 & tail.s2, {MagSize{1'b0}}};
        end else if (tail.zero1) begin
            sel_result = {tail.s2, tail.mag2};
        end else if (tail.zero2) begin
            sel_result = {tail.s1, tail.mag1};
        end else if (tail.eq_cancel) begin
            sel_result = '0;
        end else if (DpExpCarry || (DpExponent == '1)) begin
            sel_result = {tail.s_large, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
            ev[1]      = 1'b1;
        end else if (DpExponent == '0) begin
            sel_result = {tail.s_large, {MagSize{1'b0}}};
            ev[0]      = 1'b1;
        end else begin
            sel_result = {tail.s_large, DpExponent, DpFraction};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 1; k <= LATENCY; k++) begin
                dl[k] <= '0;
            end
            Result      <= '0;
            ResultValid <= 1'b0;
            Flags       <= '0;
        end else begin
            dl[1] <= issue_entry;
            for (int k = 2; k <= LATENCY; k++) begin
                dl[k] <= dl[k-1];
            end
            ResultValid <= tail.valid;
            if (tail.valid) begin
                Result <= sel_result;
            end
            // A clear in the same cycle as a new event keeps only the new event's bits.
            Flags <= (FlagClr ? 3'b000 : Flags) | (tail.valid ? ev : 3'b000);
        end
    end

`ifdef FPU_EXC_COUNT_EN
    logic exc_event;
    logic [15:0] exc_count;

    assign exc_event = tail.valid && (ev != 3'b000);
    assign ExcCount  = exc_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exc_count <= '0;
        end else if (FlagClr) begin
            exc_count <= exc_event ? 16'd1 : 16'd0;
        end else if (exc_event && (exc_count != 16'hFFFF)) begin
            exc_count <= exc_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_exception_stage.sv
// Directed-vector bench for fpu_exception_stage: table of single operations plus
// hand-written sequences for sticky flags, clear/set collisions, streaming and reset.
module tb_fpu_exception_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IssueValid = 1'b0;
    logic [31:0] IssueOperand1 = '0;
    logic [31:0] IssueOperand2 = '0;
    logic        IssueOperation = 1'b0;
    logic [7:0]  DpExponent = '0;
    logic [22:0] DpFraction = '0;
    logic        DpExpCarry = 1'b0;
    logic        FlagClr = 1'b0;
    logic [31:0] Result;
    logic        ResultValid;
    logic [2:0]  Flags;
`ifdef FPU_EXC_COUNT_EN
    logic [15:0] ExcCount;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    fpu_exception_stage dut (
        .CLK(CLK), .RST_N(RST_N), .IssueValid(IssueValid),
        .IssueOperand1(IssueOperand1), .IssueOperand2(IssueOperand2),
        .IssueOperation(IssueOperation), .DpExponent(DpExponent),
        .DpFraction(DpFraction), .DpExpCarry(DpExpCarry), .FlagClr(FlagClr),
        .Result(Result), .ResultValid(ResultValid), .Flags(Flags)
`ifdef FPU_EXC_COUNT_EN
        , .ExcCount(ExcCount)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        oper;
        logic [7:0]  dexp;
        logic [22:0] dfrac;
        logic        dcarry;
        logic [31:0] exp_res;
        logic [2:0]  exp_flg;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pulse_clr();
        FlagClr = 1'b1;
        @(posedge CLK); #1;
        FlagClr = 1'b0;
        check("flags_cleared", {29'd0, Flags}, 32'd0);
    endtask

    // Issue one op, drive its datapath values in the tail cycle, check the 7-edge result.
    task automatic run_vec(input vec_t v, input logic [2:0] exp_flags, input bit clr_at_tail);
        @(posedge CLK); #1;
        IssueValid = 1'b1; IssueOperand1 = v.op1; IssueOperand2 = v.op2; IssueOperation = v.oper;
        @(posedge CLK); #1;
        IssueValid = 1'b0; IssueOperand1 = '0; IssueOperand2 = '0; IssueOperation = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("valid_early", {31'd0, ResultValid}, 32'd0);
        DpExponent = v.dexp; DpFraction = v.dfrac; DpExpCarry = v.dcarry;
        FlagClr = clr_at_tail;
        @(posedge CLK); #1;
        FlagClr = 1'b0;
        DpExponent = '0; DpFraction = '0; DpExpCarry = 1'b0;
        check("valid_at_7", {31'd0, ResultValid}, 32'd1);
        check("result", Result, v.exp_res);
        check("flags", {29'd0, Flags}, {29'd0, exp_flags});
    endtask

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 8'h80, 23'h400000, 1'b0, 32'h40400000, 3'b000};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b1, 8'h80, 23'h000000, 1'b0, 32'hC0000000, 3'b000};
        vecs[2]  = '{32'h7F800000, 32'h7F800000, 1'b1, 8'h55, 23'h2AAAAA, 1'b0, 32'h7FC00000, 3'b100};
        vecs[3]  = '{32'h80000000, 32'h80000000, 1'b0, 8'h55, 23'h2AAAAA, 1'b0, 32'h80000000, 3'b000};
        vecs[4]  = '{32'h40A00000, 32'h40A00000, 1'b1, 8'h55, 23'h2AAAAA, 1'b0, 32'h00000000, 3'b000};
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 23'h000000, 1'b1, 32'h7F800000, 3'b010};
        vecs[6]  = '{32'hBF800000, 32'h3F000000, 1'b0, 8'h00, 23'h000000, 1'b0, 32'h80000000, 3'b001};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 8'h55, 23'h2AAAAA, 1'b0, 32'h7FC00000, 3'b100};
        vecs[8]  = '{32'h00000000, 32'h40400000, 1'b1, 8'h55, 23'h2AAAAA, 1'b0, 32'hC0400000, 3'b000};
        vecs[9]  = '{32'h3F800000, 32'h7F800000, 1'b1, 8'h55, 23'h2AAAAA, 1'b0, 32'hFF800000, 3'b000};
        vecs[10] = '{32'h7F000000, 32'h7F000000, 1'b0, 8'hFF, 23'h000000, 1'b0, 32'h7F800000, 3'b010};
        vecs[11] = '{32'h00000001, 32'h3F800000, 1'b0, 8'h55, 23'h2AAAAA, 1'b0, 32'h3F800000, 3'b000};

        // Reset state, asserted before any clock edge.
        #2;
        check("rst_result", Result, 32'd0);
        check("rst_valid", {31'd0, ResultValid}, 32'd0);
        check("rst_flags", {29'd0, Flags}, 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], vecs[i].exp_flg, 1'b0);
            pulse_clr();
        end

        // Overflow stays sticky across a later clean result.
        run_vec(vecs[5], 3'b010, 1'b0);
        run_vec(vecs[0], 3'b010, 1'b0);
        pulse_clr();

        // Underflow pending, then clear collides with a new overflow.
        run_vec(vecs[6], 3'b001, 1'b0);
        run_vec(vecs[5], 3'b010, 1'b1);
        pulse_clr();

        // Ten back-to-back issues; op c carries fraction c through the datapath.
        for (int c = 0; c < 18; c++) begin
            IssueValid     = (c < 10);
            IssueOperand1  = 32'h3F800000;
            IssueOperand2  = 32'h3F800000;
            IssueOperation = 1'b0;
            DpExponent     = 8'h80;
            DpFraction     = (c >= 6) ? 23'(c - 6) : 23'd0;
            @(posedge CLK); #1;
            if (c >= 6 && c < 16) begin
                check("stream_valid", {31'd0, ResultValid}, 32'd1);
                check("stream_result", Result, {1'b0, 8'h80, 23'(c - 6)});
            end else begin
                check("stream_idle", {31'd0, ResultValid}, 32'd0);
            end
        end
        IssueValid = 1'b0; IssueOperand1 = '0; IssueOperand2 = '0; DpExponent = '0; DpFraction = '0;

`ifdef FPU_EXC_COUNT_EN
        pulse_clr();
        check("cnt_zero", {16'd0, ExcCount}, 32'd0);
        for (int i = 0; i < 3; i++) run_vec(vecs[7], 3'b100, 1'b0);
        check("cnt_three", {16'd0, ExcCount}, 32'd3);
        run_vec(vecs[7], 3'b100, 1'b1);
        check("cnt_clr_and_event", {16'd0, ExcCount}, 32'd1);
        pulse_clr();
        check("cnt_cleared", {16'd0, ExcCount}, 32'd0);
        @(posedge CLK); #1;
        force dut.exc_count = 16'hFFFE;
        #1;
        release dut.exc_count;
        for (int i = 0; i < 3; i++) run_vec(vecs[7], 3'b100, 1'b0);
        check("cnt_saturate", {16'd0, ExcCount}, 32'h0000FFFF);
        pulse_clr();
        check("cnt_clr_after_sat", {16'd0, ExcCount}, 32'd0);
`endif

        // Leave a flag and a result behind, then reset mid-flight.
        run_vec(vecs[5], 3'b010, 1'b0);
        @(posedge CLK); #1;
        IssueValid = 1'b1; IssueOperand1 = vecs[0].op1; IssueOperand2 = vecs[0].op2;
        @(posedge CLK); #1;
        IssueValid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("async_rst_result", Result, 32'd0);
        check("async_rst_flags", {29'd0, Flags}, 32'd0);
        check("async_rst_valid", {31'd0, ResultValid}, 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            DpExponent = vecs[0].dexp; DpFraction = vecs[0].dfrac;
            repeat (10) begin
                @(posedge CLK); #1;
                if (ResultValid) seen = 1'b1;
            end
            check("rst_drops_op", {31'd0, seen}, 32'd0);
            check("rst_result_held", Result, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fpu_exception_stage.md
Name: fpu_exception_stage

Overview:
- Final pipeline stage of the single-precision add/sub FPU. It sits directly after the stage-5 FinalExponent/FinalFraction registers.
- Tracks per-operation side-band data (operand classes, result sign) through a delay line that stays aligned with the datapath.
- Computes the true result sign and applies IEEE-754 special-value handling (NaN, Inf, zero, overflow, underflow).
- Registers the final 32-bit Result with a valid bit and sticky exception flags.

Parameters:
- LATENCY, 6, issue-to-datapath-result delay in clock edges; also the side-band delay-line depth.
- DataSize, 32, operand/result width.
- ExponentSize, 8, exponent width.
- FractionSize, 23, fraction width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IssueValid  input  1  an operation is presented to the FPU inputs this cycle.
- IssueOperand1  input  32  same value as the FPU Operand1 input this cycle.
- IssueOperand2  input  32  same value as the FPU Operand2 input this cycle.
- IssueOperation  input  1  0 = add, 1 = subtract.
- DpExponent  input  8  stage-5 registered exponent.
- DpFraction  input  23  stage-5 registered fraction.
- DpExpCarry  input  1  exponent-adder carry out of stage 5; means overflow.
- FlagClr  input  1  clears the sticky flags.
- Result  output  32  final {sign, exponent, fraction}.
- ResultValid  output  1  Result holds a new operation's result this cycle.
- Flags  output  3  sticky {Invalid, Overflow, Underflow}.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All delay-line valid bits clear.
  - Result=0, ResultValid=0, Flags=0.
  - In-flight operations are dropped. Upstream stages have no reset, so datapath values arriving later are ignored because their delay-line valid bit is 0.
- Issue decode (combinational on the Issue* inputs, pushed into the delay line every cycle, valid bit = IssueValid):
  - Effective sign of operand 2: s2 = IssueOperand2[31] ^ IssueOperation.
  - Classes per operand:
    - NaN: exp=FF and frac≠0.
    - Inf: exp=FF and frac=0.
    - Zero: exp=0; denormals are flushed to zero.
    - Otherwise Finite.
  - Larger-magnitude select: compare {exp,frac} unsigned.
  - EqualCancel: magnitudes equal, both finite, and s1≠s2.
- Delay line:
  - LATENCY-deep shift register, shifts every cycle; there is no stall.
  - Entry k is issued k edges earlier.
  - The tail entry is aligned with the Dp* inputs in the same cycle.
- Result selection (tail entry, highest priority first):
  1. Either operand NaN, or Inf+Inf with opposite effective signs → 0x7FC00000; set Invalid.
  2. Either operand Inf → signed Inf (exp=FF, frac=0) carrying that Inf's effective sign.
  3. Both operands Zero → sign = s1 & s2, i.e. -0 only for (-0)+(-0); exp=0, frac=0.
  4. Exactly one operand Zero → the other operand with its effective sign, bypassing the datapath.
  5. EqualCancel → +0 (0x00000000).
  6. DpExpCarry=1 or DpExponent=FF → signed Inf; set Overflow.
  7. DpExponent=0 → signed zero; set Underflow.
  8. Otherwise → {sign of the larger-magnitude operand, DpExponent, DpFraction}.
- Output register:
  - Captures the selection on the next edge; ResultValid <= tail valid.
  - Total latency from IssueValid to ResultValid = LATENCY+1 edges (7 by default).
  - Result holds its value when ResultValid=0.
- Flags:
  - Sticky OR of per-result events, updated only for valid tail entries.
  - FlagClr clears all flags.
  - Set and clear in the same cycle: set wins for the bits being set; the other bits clear.
- Back-to-back issues every cycle give one valid result every cycle, in issue order.

Optional Feature:
- Macro FPU_EXC_COUNT_EN.
- Defined:
  - Adds output ExcCount [15:0]: count of valid results that set any flag.
  - Saturates at 0xFFFF; reset to 0 by RST_N and by FlagClr.
  - If FlagClr and an exception occur in the same cycle, ExcCount = 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Normal add: 0x3F800000 + 0x40000000, with Dp* driven to {0x80, 0x400000} at tail time → ResultValid pulses 7 edges after issue with Result=0x40400000; Flags=0.
- Sign from larger operand: 0x3F800000 − 0x40400000 (Op=1), Dp={0x80, 0x000000} → Result=0xC0000000.
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000 and Flags=3'b100.
  - 0x80000000 + 0x80000000 → 0x80000000.
  - 0x40A00000 − 0x40A00000 → 0x00000000.
- Overflow/underflow:
  - DpExpCarry=1 with sign + → 0x7F800000; Overflow set and sticky across later clean results.
  - Clear, then DpExponent=0 → signed zero; Underflow set.
  - FlagClr pulsed in the same cycle as a new Overflow → Flags=3'b010.
- Streaming and reset:
  - 10 back-to-back issues → 10 consecutive ResultValid cycles, in order.
  - RST_N low for 1 cycle at edge 3 after issue → no ResultValid for that op; Result=0, Flags=0 immediately (asynchronous).
- FPU_EXC_COUNT_EN:
  - 3 NaN operations → ExcCount=3.
  - Preload near 0xFFFF → ExcCount holds 0xFFFF.
  - FlagClr → ExcCount=0.
